// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared definitions for the hazard detection unit.
//   REG_AW     : register-address width
//   optype_e   : ID/EX/MEM operation class (none, ALU, load, store)
//   fwd_sel_e  : ID operand source select
//   writes_reg : true for operation classes that produce a register result
package hazard_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } optype_e;

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,
        FWD_EX_ALU   = 2'b01,
        FWD_MEM_ALU  = 2'b10,
        FWD_MEM_LOAD = 2'b11
    } fwd_sel_e;

    function automatic logic writes_reg(input optype_e op);
        return (op == OP_ALU) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// hazard_detection_unit_if -- ID-stage hazard interface.
//   ID fields (driven by the decode stage): rs1_ID, rs2_ID, rd_ID,
//     rs1use_ID, rs2use_ID, hazard_optype_ID, Branch_ID
//   Pipeline controls (driven by the hazard unit): PC_EN_IF, reg_FD_EN,
//     reg_FD_flush, reg_DE_flush, forward_ctrl_A, forward_ctrl_B,
//     forward_ctrl_ls
//   Debug view of the EX/MEM trackers: *_dbg
// There is no valid/ready handshake here: the ID fields are sampled every
// cycle and the controls are a pure combinational response to them plus the
// trackers, so both sides are always "valid" and nothing ever back-pressures.
// modport slave  : the hazard unit
// modport master : the decode stage / testbench
interface hazard_detection_unit_if #(
    parameter int REG_AW = hazard_pkg::REG_AW
);
    logic [REG_AW-1:0] rs1_ID;
    logic [REG_AW-1:0] rs2_ID;
    logic [REG_AW-1:0] rd_ID;
    logic              rs1use_ID;
    logic              rs2use_ID;
    logic [1:0]        hazard_optype_ID;
    logic              Branch_ID;

    logic              PC_EN_IF;
    logic              reg_FD_EN;
    logic              reg_FD_flush;
    logic              reg_DE_flush;
    logic [1:0]        forward_ctrl_A;
    logic [1:0]        forward_ctrl_B;
    logic              forward_ctrl_ls;

    logic [1:0]        ex_optype_dbg;
    logic [REG_AW-1:0] ex_rd_dbg;
    logic [REG_AW-1:0] ex_rs2_dbg;
    logic [1:0]        mem_optype_dbg;
    logic [REG_AW-1:0] mem_rd_dbg;
    logic [REG_AW-1:0] mem_rs2_dbg;

    modport slave (
        input  rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID,
               hazard_optype_ID, Branch_ID,
        output PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls,
               ex_optype_dbg, ex_rd_dbg, ex_rs2_dbg,
               mem_optype_dbg, mem_rd_dbg, mem_rs2_dbg
    );

    modport master (
        output rs1_ID, rs2_ID, rd_ID, rs1use_ID, rs2use_ID,
               hazard_optype_ID, Branch_ID,
        input  PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
               forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls,
               ex_optype_dbg, ex_rd_dbg, ex_rs2_dbg,
               mem_optype_dbg, mem_rd_dbg, mem_rs2_dbg
    );

endinterface

// File: rtl/hazard_stage_tracker.sv
// hazard_stage_tracker -- two-entry EX/MEM shadow of the pipeline.
//   clk, rst          : clock, asynchronous active-high reset
//   flush             : insert a bubble into EX instead of the ID fields
//   id_op/id_rd/id_rs2: fields of the instruction leaving ID
//   ex_* / mem_*      : tracked optype, rd and rs2 in EX and MEM
module hazard_stage_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW = hazard_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  optype_e           id_op,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs2,
    output optype_e           ex_op,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_rs2,
    output optype_e           mem_op,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] mem_rs2
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_op   <= OP_NONE;
            ex_rd   <= '0;
            ex_rs2  <= '0;
            mem_op  <= OP_NONE;
            mem_rd  <= '0;
            mem_rs2 <= '0;
        end else begin
            if (flush) begin
                // Bubble: no register result, so it can never match.
                ex_op  <= OP_NONE;
                ex_rd  <= '0;
                ex_rs2 <= '0;
            end else begin
                ex_op  <= id_op;
                ex_rd  <= id_rd;
                ex_rs2 <= id_rs2;
            end
            mem_op  <= ex_op;
            mem_rd  <= ex_rd;
            mem_rs2 <= ex_rs2;
        end
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit -- ID-stage load-use stall, branch flush and
// operand forwarding control for a 5-stage pipeline.
//   clk, rst : pipeline clock, asynchronous active-high reset
//   hif      : hazard_detection_unit_if.slave (ID fields in, controls out)
// Optional feature: HAZARD_STORE_FWD_EN -- when defined, a store whose only
// dependency on a load in EX is its store data (rs2) does not stall; the
// data is picked up from MEM one cycle later via forward_ctrl_ls.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = hazard_pkg::REG_AW
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_detection_unit_if.slave  hif
);

    optype_e           id_op;
    optype_e           ex_op;
    optype_e           mem_op;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] mem_rs2;
    logic              de_flush;

    assign id_op = optype_e'(hif.hazard_optype_ID);

    hazard_stage_tracker #(.REG_AW(REG_AW)) u_tracker (
        .clk     (clk),
        .rst     (rst),
        .flush   (de_flush),
        .id_op   (id_op),
        .id_rd   (hif.rd_ID),
        .id_rs2  (hif.rs2_ID),
        .ex_op   (ex_op),
        .ex_rd   (ex_rd),
        .ex_rs2  (ex_rs2),
        .mem_op  (mem_op),
        .mem_rd  (mem_rd),
        .mem_rs2 (mem_rs2)
    );

    // A source matches a stage when it is used, nonzero (x0 is never a real
    // dependency) and equal to a stage that actually writes a register.
    logic ex_a, ex_b, mem_a, mem_b;
    always_comb begin
        ex_a  = hif.rs1use_ID && (hif.rs1_ID != '0) && (hif.rs1_ID == ex_rd)
                && writes_reg(ex_op);
        ex_b  = hif.rs2use_ID && (hif.rs2_ID != '0) && (hif.rs2_ID == ex_rd)
                && writes_reg(ex_op);
        mem_a = hif.rs1use_ID && (hif.rs1_ID != '0) && (hif.rs1_ID == mem_rd)
                && writes_reg(mem_op);
        mem_b = hif.rs2use_ID && (hif.rs2_ID != '0) && (hif.rs2_ID == mem_rd)
                && writes_reg(mem_op);
    end

    function automatic fwd_sel_e pick_fwd(input logic ex_m, input logic mem_m);
        // The youngest producer wins; a load still in EX has no data yet,
        // so it yields no forward (the stall covers that case).
        if (ex_m && ex_op == OP_ALU)         return FWD_EX_ALU;
        else if (mem_m && mem_op == OP_ALU)  return FWD_MEM_ALU;
        else if (mem_m && mem_op == OP_LOAD) return FWD_MEM_LOAD;
        else                                 return FWD_RF;
    endfunction

    logic load_use;
    logic ls_fwd;
    always_comb begin
`ifdef HAZARD_STORE_FWD_EN
        // Store data can wait until EX, where the load result is in MEM.
        load_use = (ex_op == OP_LOAD) &&
                   (ex_a || (ex_b && id_op != OP_STORE));
        ls_fwd   = (ex_op == OP_STORE) && (mem_op == OP_LOAD) &&
                   (mem_rd != '0) && (ex_rs2 == mem_rd);
`else
        load_use = (ex_op == OP_LOAD) && (ex_a || ex_b);
        ls_fwd   = 1'b0;
`endif
    end

    // Reset forces the quiet control set regardless of what ID presents.
    always_comb begin
        hif.PC_EN_IF        = 1'b1;
        hif.reg_FD_EN       = 1'b1;
        hif.reg_FD_flush    = 1'b0;
        de_flush            = 1'b0;
        hif.forward_ctrl_A  = FWD_RF;
        hif.forward_ctrl_B  = FWD_RF;
        hif.forward_ctrl_ls = 1'b0;
        if (!rst) begin
            hif.forward_ctrl_A  = pick_fwd(ex_a, mem_a);
            hif.forward_ctrl_B  = pick_fwd(ex_b, mem_b);
            hif.forward_ctrl_ls = ls_fwd;
            if (load_use) begin
                // Branch outcome is computed from stale operands; ignore it.
                hif.PC_EN_IF  = 1'b0;
                hif.reg_FD_EN = 1'b0;
                de_flush      = 1'b1;
            end else begin
                hif.reg_FD_flush = hif.Branch_ID;
            end
        end
    end

    assign hif.reg_DE_flush   = de_flush;
    assign hif.ex_optype_dbg  = ex_op;
    assign hif.ex_rd_dbg      = ex_rd;
    assign hif.ex_rs2_dbg     = ex_rs2;
    assign hif.mem_optype_dbg = mem_op;
    assign hif.mem_rd_dbg     = mem_rd;
    assign hif.mem_rs2_dbg    = mem_rs2;

endmodule
